// File: rtl/stim_pkg.sv
// Shared encodings and the LFSR tap table for the stimulus sweep generator.
package stim_pkg;

  // Sweep modes as sampled on an accepted start.
  localparam logic [1:0] MODE_EXH   = 2'd0;
  localparam logic [1:0] MODE_WALK1 = 2'd1;
  localparam logic [1:0] MODE_LFSR  = 2'd2;
  localparam logic [1:0] MODE_BAD   = 2'd3;

  // Sweep controller states.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  // Single tap bit for a 1-based register position.
  function automatic logic [31:0] tap_bit(input int unsigned pos);
    return 32'(32'd1 << (pos - 1));
  endfunction

  // Maximal-length Fibonacci tap mask for a register of w bits (2..32).
  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      2:       return tap_bit(2)  | tap_bit(1);
      3:       return tap_bit(3)  | tap_bit(2);
      4:       return tap_bit(4)  | tap_bit(3);
      5:       return tap_bit(5)  | tap_bit(3);
      6:       return tap_bit(6)  | tap_bit(5);
      7:       return tap_bit(7)  | tap_bit(6);
      8:       return tap_bit(8)  | tap_bit(6)  | tap_bit(5) | tap_bit(4);
      9:       return tap_bit(9)  | tap_bit(5);
      10:      return tap_bit(10) | tap_bit(7);
      11:      return tap_bit(11) | tap_bit(9);
      12:      return tap_bit(12) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
      13:      return tap_bit(13) | tap_bit(4)  | tap_bit(3) | tap_bit(1);
      14:      return tap_bit(14) | tap_bit(5)  | tap_bit(3) | tap_bit(1);
      15:      return tap_bit(15) | tap_bit(14);
      16:      return tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17:      return tap_bit(17) | tap_bit(14);
      18:      return tap_bit(18) | tap_bit(11);
      19:      return tap_bit(19) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
      20:      return tap_bit(20) | tap_bit(17);
      21:      return tap_bit(21) | tap_bit(19);
      22:      return tap_bit(22) | tap_bit(21);
      23:      return tap_bit(23) | tap_bit(18);
      24:      return tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      25:      return tap_bit(25) | tap_bit(22);
      26:      return tap_bit(26) | tap_bit(6)  | tap_bit(2) | tap_bit(1);
      27:      return tap_bit(27) | tap_bit(5)  | tap_bit(2) | tap_bit(1);
      28:      return tap_bit(28) | tap_bit(25);
      29:      return tap_bit(29) | tap_bit(27);
      30:      return tap_bit(30) | tap_bit(6)  | tap_bit(4) | tap_bit(1);
      31:      return tap_bit(31) | tap_bit(28);
      32:      return tap_bit(32) | tap_bit(22) | tap_bit(2) | tap_bit(1);
      default: return 32'd0;
    endcase
  endfunction

endpackage

// File: rtl/stim_lfsr.sv
// Fibonacci LFSR: load seeds the register with 1, advance steps it once.
module stim_lfsr
  import stim_pkg::*;
#(
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  logic fb_c;

  // Feedback is the parity of the tapped bits.
  assign fb_c = ^(state & TAPS);

  // Shift register; load wins over advance so a new sweep always starts at the seed.
  always_ff @(posedge clk) begin
    if (rst)          state <= '0;
    else if (load)    state <= WIDTH'(1);
    else if (advance) state <= {state[WIDTH-2:0], fb_c};
  end

endmodule

// File: rtl/stim_sweep_gen.sv
// Stimulus sweep generator: exhaustive, walking-one or LFSR vector sweeps with a
// minimum hold time per vector and a ready/valid handshake toward the consumer.
module stim_sweep_gen
  import stim_pkg::*;
#(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned HOLD  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic             abort,
  input  logic             vec_ready,
  output logic [WIDTH-1:0] vec_out,
  output logic             vec_valid,
  output logic [WIDTH:0]   vec_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned IW     = WIDTH + 1;
  localparam int unsigned HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD - 1);
  localparam logic [IW-1:0]     LAST_EXH  = {1'b0, {WIDTH{1'b1}}};
  localparam logic [IW-1:0]     LAST_WALK = IW'(WIDTH - 1);
  localparam logic [IW-1:0]     LAST_LFSR = LAST_EXH - IW'(1);

  // Reject unsupported configurations at elaboration.
  if (WIDTH < 2 || WIDTH > 32 || HOLD < 1) begin : g_bad_param
    $error("stim_sweep_gen: WIDTH must be 2..32 and HOLD at least 1");
  end

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [WIDTH-1:0]  vec_q, vec_d;
  logic              valid_d;
  logic [IW-1:0]     idx_d;
  logic [HOLD_W-1:0] hold_cnt, hold_d;
  logic              busy_d, done_d, err_d;
  logic              lfsr_load, lfsr_adv;
  logic [WIDTH-1:0]  lfsr_state;
  logic              is_last_c;

  stim_lfsr #(.WIDTH(WIDTH)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .advance (lfsr_adv),
    .state   (lfsr_state)
  );

  // In LFSR mode the LFSR register itself carries the current vector.
  assign vec_out = (mode_q == MODE_LFSR) ? lfsr_state : vec_q;

  // Terminal vector is recognised by index, so counters never need to wrap.
  always_comb begin
    is_last_c = 1'b0;
    case (mode_q)
      MODE_EXH:   is_last_c = (vec_idx == LAST_EXH);
      MODE_WALK1: is_last_c = (vec_idx == LAST_WALK);
      MODE_LFSR:  is_last_c = (vec_idx == LAST_LFSR);
      default:    is_last_c = 1'b1;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    vec_d     = vec_q;
    valid_d   = vec_valid;
    idx_d     = vec_idx;
    hold_d    = hold_cnt;
    done_d    = 1'b0;
    err_d     = err;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          mode_d = mode;
          idx_d  = '0;
          hold_d = '0;
          err_d  = 1'b0;
          if (mode == MODE_BAD) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end else begin
            valid_d   = 1'b1;
            state_d   = ST_RUN;
            vec_d     = (mode == MODE_EXH) ? '0 : WIDTH'(1);
            lfsr_load = (mode == MODE_LFSR);
          end
        end
      end

      ST_RUN: begin
        if (abort) begin
          valid_d = 1'b0;
          hold_d  = '0;
          state_d = ST_IDLE;
        end else if (vec_valid && vec_ready && hold_cnt == HOLD_MAX) begin
          hold_d = '0;
          if (is_last_c) begin
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = ST_FINISH;
          end else begin
            idx_d = vec_idx + IW'(1);
            case (mode_q)
              MODE_EXH:   vec_d = vec_q + WIDTH'(1);
              MODE_WALK1: vec_d = {vec_q[WIDTH-2:0], 1'b0};
              default:    lfsr_adv = 1'b1;
            endcase
          end
        end else if (hold_cnt != HOLD_MAX) begin
          hold_d = hold_cnt + HOLD_W'(1);
        end
      end

      ST_FINISH: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_EXH;
      vec_q     <= '0;
      vec_valid <= 1'b0;
      vec_idx   <= '0;
      hold_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      vec_q     <= vec_d;
      vec_valid <= valid_d;
      vec_idx   <= idx_d;
      hold_cnt  <= hold_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

endmodule
